store_lane_unit: RTL and testbench
==================================

// Module: store_lane_unit
// PURPOSE
//  Write-side counterpart of the core's result-select muxing: takes one store op (address, rs2 data,
//  size) and distributes it onto data-memory byte lanes with byte enables. Sits between execute
//  and the data-memory port; holds one registered request until the memory grants it. Traps
//  misaligned or illegal-size stores instead of issuing them.
// PARAMETERS
//  XLEN   32  data/address width (32 only; byte-lane logic is fixed at 4 lanes)
//  CNT_W  16  width of the completed-store counter
// PORTS
//  clk           in   1      core clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      execute presents a store op
//  in_ready      out  1      unit can accept this cycle
//  in_addr       in   XLEN   byte address (rs1+imm)
//  in_wdata      in   XLEN   rs2 value, right-justified
//  in_size       in   2      funct3[1:0]: 00=SB 01=SH 10=SW 11=illegal
//  flush         in   1      pipeline flush; drops ungranted request
//  mem_req       out  1      request valid toward data memory
//  mem_gnt       in   1      memory accepts request this cycle
//  mem_addr      out  XLEN   word address {in_addr[31:2],2'b00}
//  mem_wdata     out  XLEN   lane-replicated write data
//  mem_be        out  4      byte enables
//  misaligned    out  1      one-cycle fault pulse
//  fault_addr    out  XLEN   faulting byte address, held until next fault
//  store_count   out  CNT_W  number of granted stores, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): mem_req=0, mem_addr/mem_wdata/fault_addr=0, mem_be=0, misaligned=0,
//    store_count=0; FSM in IDLE.
//  - FSM: IDLE (no request held) / PEND (request held, mem_req=1).
//    in_ready = !flush && (IDLE || mem_gnt).  Accept = in_valid && in_ready.
//    IDLE: accept of aligned op -> PEND. PEND: mem_gnt && !accept-aligned -> IDLE;
//    mem_gnt && accept-aligned -> stay PEND with new payload (back-to-back, no bubble);
//    flush && !mem_gnt -> IDLE (request dropped); flush && mem_gnt -> grant counts, -> IDLE.
//  - Latency: accepted op appears on mem_* the cycle after acceptance. While PEND and !mem_gnt,
//    mem_addr/mem_wdata/mem_be held stable.
//  - Lane steering, off = in_addr[1:0]:
//    SB: wdata={4{d[7:0]}},  be=4'b0001<<off
//    SH: wdata={2{d[15:0]}}, be=4'b0011<<off (off[0] must be 0)
//    SW: wdata=d,            be=4'b1111      (off must be 0)
//  - Fault: SH with off[0]=1, SW with off!=0, or size=11. Op is consumed (handshake completes),
//    no memory request issued, misaligned=1 next cycle for exactly one cycle, fault_addr=in_addr.
//    Fault accept leaves FSM state as set by mem_gnt alone.
//  - store_count increments by 1 on every cycle with mem_req && mem_gnt; wraps all-ones -> 0.
//  - mem_gnt while mem_req=0 is ignored. flush has priority over in_valid.
//  - Reset asserted mid-PEND drops request immediately (mem_req falls asynchronously).
// STRUCTURE
//  - Shared package rv32_pkg: store_size_t enum (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_ILL=2'b11),
//    store_state_t enum (ST_IDLE, ST_PEND).
//  - Sub-module store_lane_steer (combinational): {addr[1:0], size, data} -> {wdata, be, fault}.
//    Top module holds FSM, payload register, fault register, counter.
// TESTING
//  1. SB addr=0x1003 d=0x000000A5, mem_gnt=1 -> next cycle mem_req=1 addr=0x1000
//     wdata=0xA5A5A5A5 be=1000; store_count 0->1.
//  2. SH addr=0x2002 d=0x1234 with mem_gnt=0 for 3 cycles -> mem_req/wdata=0x12341234/be=1100
//     stable 3 cycles, in_ready=0; gnt on 4th -> IDLE.
//  3. SW addr=0x3001 -> no mem_req, misaligned pulse 1 cycle, fault_addr=0x3001; in_size=11 at
//     0x4000 -> same, fault_addr=0x4000.
//  4. Back-to-back SW 0x10,0x14,0x18 with mem_gnt=1 -> mem_req continuous 3 cycles, no bubble,
//     count +3.
//  5. PEND SW 0x20 gnt=0, flush=1 -> mem_req=0 next cycle, count unchanged, in_valid that cycle
//     not accepted; repeat with gnt=1 -> count +1.
//  6. rst_n low mid-PEND -> mem_req=0 before next edge; count preset to 0xFFFF then one grant
//     -> 0x0000.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared store-path types: access size encoding (funct3[1:0]) and the
// request-holding FSM states.
package rv32_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } store_size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } store_state_t;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational lane steering: replicates store data across the 4 byte lanes
// and builds byte enables from the low address bits; flags misaligned/illegal ops.
module store_lane_steer
    import rv32_pkg::*;
(
    input  logic [1:0]  off,
    input  store_size_t size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        fault
);

    always_comb begin
        wdata = data;
        be    = 4'b0000;
        fault = 1'b0;
        case (size)
            SZ_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << off;
            end
            SZ_H: begin
                wdata = {2{data[15:0]}};
                be    = 4'b0011 << off;
                fault = off[0];
            end
            SZ_W: begin
                wdata = data;
                be    = 4'b1111;
                fault = (off != 2'b00);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store issue stage: registers one steered store request and holds it toward
// data memory until granted; misaligned/illegal stores are trapped, not issued.
module store_lane_unit
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  store_size_t       in_size,
    input  logic              flush,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_be,
    output logic              misaligned,
    output logic [XLEN-1:0]   fault_addr,
    output logic [CNT_W-1:0]  store_count,
    output store_state_t      state
);

    // Handshake: an op transfers on in_valid && in_ready. in_ready is low during
    // flush, and while a request is held it follows mem_gnt so a granted slot
    // can be refilled in the same cycle (no bubble).

    store_state_t state_q, state_d;

    logic [XLEN-1:0] steer_wdata;
    logic [3:0]      steer_be;
    logic            steer_fault;
    logic            accept, accept_ok, accept_fault, grant;

    store_lane_steer u_steer (
        .off   (in_addr[1:0]),
        .size  (in_size),
        .data  (in_wdata),
        .wdata (steer_wdata),
        .be    (steer_be),
        .fault (steer_fault)
    );

    assign in_ready     = !flush && ((state_q == ST_IDLE) || mem_gnt);
    assign accept       = in_valid && in_ready;
    assign accept_ok    = accept && !steer_fault;
    assign accept_fault = accept && steer_fault;
    assign grant        = (state_q == ST_PEND) && mem_gnt;
    assign mem_req      = (state_q == ST_PEND);
    assign state        = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_ok) state_d = ST_PEND;
            end
            ST_PEND: begin
                // flush forces in_ready low, so no new op can arrive alongside it
                if (flush)        state_d = ST_IDLE;
                else if (mem_gnt) state_d = accept_ok ? ST_PEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
            misaligned  <= 1'b0;
            fault_addr  <= '0;
            store_count <= '0;
        end else begin
            state_q    <= state_d;
            misaligned <= accept_fault;
            if (accept_ok) begin
                mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                mem_wdata <= steer_wdata;
                mem_be    <= steer_be;
            end
            if (accept_fault) fault_addr <= in_addr;
            if (grant) store_count <= store_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_store_lane_unit.sv
// Directed bench for store_lane_unit: lane steering, stall/hold, faults,
// back-to-back issue, flush, async reset and counter wrap.
module tb_store_lane_unit;
    import rv32_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_addr;
    logic [31:0]  in_wdata;
    store_size_t  in_size;
    logic         flush;
    logic         mem_req;
    logic         mem_gnt;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_be;
    logic         misaligned;
    logic [31:0]  fault_addr;
    logic [15:0]  store_count;
    store_state_t state;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    store_lane_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_size     (in_size),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .misaligned  (misaligned),
        .fault_addr  (fault_addr),
        .store_count (store_count),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the active edge and settle before any comb check.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic g, input logic f);
        in_valid = v;
        in_addr  = a;
        in_wdata = d;
        in_size  = store_size_t'(sz);
        mem_gnt  = g;
        flush    = f;
        #1;
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 32'h0, 32'h0, 2'b00, g, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        check({tag, ".req"},   {31'd0, mem_req}, 32'd1);
        check({tag, ".addr"},  mem_addr, a);
        check({tag, ".wdata"}, mem_wdata, d);
        check({tag, ".be"},    {28'd0, mem_be}, {28'd0, be});
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        tick();
        check("rst.req",   {31'd0, mem_req}, 32'd0);
        check("rst.addr",  mem_addr, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        check("rst.be",    {28'd0, mem_be}, 32'd0);
        check("rst.mis",   {31'd0, misaligned}, 32'd0);
        check("rst.faddr", fault_addr, 32'd0);
        check("rst.count", {16'd0, store_count}, 32'd0);
        check("rst.state", {31'd0, state}, {31'd0, ST_IDLE});
        rst_n = 1'b1;
        tick();

        // 1: SB to the top byte lane, grant arrives while idle (ignored)
        drive(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00, 1'b1, 1'b0);
        check("t1.ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_req("t1", 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        check("t1.count0", {16'd0, store_count}, 32'd0);
        idle(1'b1);
        tick();
        check("t1.count1", {16'd0, store_count}, 32'd1);
        check("t1.reqoff", {31'd0, mem_req}, 32'd0);

        // 2: SH held for three ungranted cycles, then granted
        drive(1'b1, 32'h0000_2002, 32'h0000_1234, 2'b01, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_2F00, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
            check($sformatf("t2.ready%0d", i), {31'd0, in_ready}, 32'd0);
            check_req($sformatf("t2.hold%0d", i), 32'h0000_2000, 32'h1234_1234, 4'b1100);
            tick();
        end
        idle(1'b1);
        tick();
        check("t2.req", {31'd0, mem_req}, 32'd0);
        check("t2.count", {16'd0, store_count}, 32'd2);

        // 3: misaligned SW and illegal size are consumed and trapped
        drive(1'b1, 32'h0000_3001, 32'h1111_2222, 2'b10, 1'b0, 1'b0);
        check("t3.ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("t3.req", {31'd0, mem_req}, 32'd0);
        check("t3.mis", {31'd0, misaligned}, 32'd1);
        check("t3.faddr", fault_addr, 32'h0000_3001);
        idle(1'b0);
        tick();
        check("t3.mis_off", {31'd0, misaligned}, 32'd0);
        check("t3.faddr_hold", fault_addr, 32'h0000_3001);
        drive(1'b1, 32'h0000_4000, 32'h3333_4444, 2'b11, 1'b0, 1'b0);
        tick();
        check("t3.ill_req", {31'd0, mem_req}, 32'd0);
        check("t3.ill_mis", {31'd0, misaligned}, 32'd1);
        check("t3.ill_faddr", fault_addr, 32'h0000_4000);
        idle(1'b0);
        tick();
        check("t3.ill_mis_off", {31'd0, misaligned}, 32'd0);
        check("t3.count", {16'd0, store_count}, 32'd2);

        // 4: back-to-back SWs with grant held, no bubble
        drive(1'b1, 32'h0000_0010, 32'hAAAA_0010, 2'b10, 1'b0, 1'b0);
        tick();
        check_req("t4.a", 32'h0000_0010, 32'hAAAA_0010, 4'b1111);
        drive(1'b1, 32'h0000_0014, 32'hAAAA_0014, 2'b10, 1'b1, 1'b0);
        tick();
        check_req("t4.b", 32'h0000_0014, 32'hAAAA_0014, 4'b1111);
        drive(1'b1, 32'h0000_0018, 32'hAAAA_0018, 2'b10, 1'b1, 1'b0);
        tick();
        check_req("t4.c", 32'h0000_0018, 32'hAAAA_0018, 4'b1111);
        idle(1'b1);
        tick();
        check("t4.req", {31'd0, mem_req}, 32'd0);
        check("t4.count", {16'd0, store_count}, 32'd5);

        // 5: flush drops an ungranted request; with grant it still counts
        drive(1'b1, 32'h0000_0020, 32'h5555_0020, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0024, 32'h5555_0024, 2'b10, 1'b0, 1'b1);
        check("t5.ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("t5.req", {31'd0, mem_req}, 32'd0);
        check("t5.count", {16'd0, store_count}, 32'd5);
        idle(1'b0);
        tick();
        check("t5.noacc", {31'd0, mem_req}, 32'd0);
        drive(1'b1, 32'h0000_0020, 32'h5555_0020, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0024, 32'h5555_0024, 2'b10, 1'b1, 1'b1);
        tick();
        check("t5.greq", {31'd0, mem_req}, 32'd0);
        check("t5.gcount", {16'd0, store_count}, 32'd6);
        idle(1'b0);
        tick();
        check("t5.gnoacc", {31'd0, mem_req}, 32'd0);

        // 7: SB/SH on other lanes, then a misaligned SH accepted under grant
        drive(1'b1, 32'h0000_0041, 32'h1234_56C3, 2'b00, 1'b0, 1'b0);
        tick();
        check_req("t7.sb", 32'h0000_0040, 32'hC3C3_C3C3, 4'b0010);
        drive(1'b1, 32'h0000_0040, 32'hABCD_BEEF, 2'b01, 1'b1, 1'b0);
        tick();
        check_req("t7.sh", 32'h0000_0040, 32'hBEEF_BEEF, 4'b0011);
        drive(1'b1, 32'h0000_0043, 32'h0000_9999, 2'b01, 1'b1, 1'b0);
        tick();
        check("t7.req", {31'd0, mem_req}, 32'd0);
        check("t7.mis", {31'd0, misaligned}, 32'd1);
        check("t7.faddr", fault_addr, 32'h0000_0043);
        check("t7.count", {16'd0, store_count}, 32'd8);

        // 6: async reset mid-request, then counter wrap
        drive(1'b1, 32'h0000_0030, 32'h7777_0030, 2'b10, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        check("t6.pend", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.req_async", {31'd0, mem_req}, 32'd0);
        check("t6.count_rst", {16'd0, store_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 65536; i++) tick();
        check("t6.count_max", {16'd0, store_count}, 32'h0000_FFFF);
        idle(1'b1);
        tick();
        check("t6.count_wrap", {16'd0, store_count}, 32'h0000_0000);
        check("t6.req_end", {31'd0, mem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
